// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
//   - MODE_* : 3-bit operation codes (6 and 7 are reserved and act as HOLD)
//   - state_t: sequencer states
//   - is_step_mode(): true for the modes that run the multi-step sequencer
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHR  = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_LOAD = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_ROL  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_step_mode(input logic [2:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL) ||
           (m == MODE_ROR) || (m == MODE_ROL);
  endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register with a multi-step sequencer.
// A start pulse in IDLE either loads/holds (completes in one cycle) or latches
// a shift/rotate mode plus a step count and runs that many single-bit steps on
// consecutive edges, then pulses done.
// Ports:
//   clk            clock, rising edge
//   mr             asynchronous active-high reset
//   start          request, sampled only in IDLE
//   mode, amt      operation and step count, captured with start
//   dsr, dsl       serial inputs for right/left shifts, sampled at each step
//   in             parallel load data
//   out            register contents
//   busy           high while steps are executing
//   done           one-cycle completion pulse
//   sout_r, sout_l cascade outputs (out MSB / out LSB)
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             mr,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amt,
  input  logic             dsr,
  input  logic             dsl,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             sout_r,
  output logic             sout_l
);

  state_t           state, state_nx;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] step_val;
  logic             last_step;
  logic             accept_step;

  assign last_step   = (cnt == CNT_W'(1));
  assign accept_step = start && is_step_mode(mode) && (amt != '0);

  // One-step next value; only consumed in RUN, so it uses the latched mode.
  // "Right" moves bits toward the MSB (194 convention): dsr enters bit 0.
  always_comb begin
    step_val = out;
    case (mode_q)
      MODE_SHR: step_val = {out[WIDTH-2:0], dsr};
      MODE_SHL: step_val = {dsl, out[WIDTH-1:1]};
      MODE_ROR: step_val = {out[WIDTH-2:0], out[WIDTH-1]};
      MODE_ROL: step_val = {out[0], out[WIDTH-1:1]};
      default:  step_val = out;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge mr) begin
    if (mr) state <= ST_IDLE;
    else    state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept_step) state_nx = ST_RUN;
      ST_RUN:  if (last_step)   state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state == ST_RUN);
  end

  // Datapath: register, step counter, latched mode, done pulse.
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      out    <= '0;
      cnt    <= '0;
      mode_q <= MODE_HOLD;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (mode == MODE_LOAD) begin
              out  <= in;
              done <= 1'b1;
            end else if (accept_step) begin
              mode_q <= mode;
              cnt    <= amt;
            end else begin
              // HOLD, reserved, or zero-step request: complete immediately
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          out <= step_val;
          cnt <= cnt - CNT_W'(1);
          if (last_step) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sout_r = out[WIDTH-1];
  assign sout_l = out[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          mr = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic [CW-1:0] amt = '0;
  logic          dsr = 1'b0;
  logic          dsl = 1'b0;
  logic [W-1:0]  in = '0;
  logic [W-1:0]  out;
  logic          busy, done, sout_r, sout_l;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .mr(mr), .start(start), .mode(mode), .amt(amt),
    .dsr(dsr), .dsl(dsl), .in(in), .out(out), .busy(busy), .done(done),
    .sout_r(sout_r), .sout_l(sout_l)
  );

  always #5 clk = ~clk;

  // Expected observation for one cycle in which busy or done is high.
  typedef struct {
    int val;
    bit dn;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cur   = 0;   // model register value

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference for one step, in plain arithmetic.
  function automatic int mstep(input int m, input int v, input int b);
    case (m)
      1: return ((v * 2) + b) % 256;         // SHR: serial bit enters LSB
      2: return (v / 2) + b * 128;           // SHL: serial bit enters MSB
      4: return ((v * 2) % 256) + (v / 128); // ROR
      5: return (v / 2) + (v % 2) * 128;     // ROL
      default: return v;
    endcase
  endfunction

  // Monitor: every cycle with busy or done consumes one expectation.
  always @(negedge clk) begin
    if (!mr && (busy || done)) begin
      if (q.size() == 0) begin
        fails++;
        tests++;
        $display("FAIL unexpected_activity: busy=%0b done=%0b with nothing pending", busy, done);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out", int'(out), e.val);
        chk("busy_done", int'({busy, done}), e.dn ? 1 : 2);
        chk("sout_r", int'(sout_r), (e.val / 128) % 2);
        chk("sout_l", int'(sout_l), e.val % 2);
      end
    end
  end

  // Mid-cycle asynchronous reset pulse with immediate checks.
  task automatic pulse_reset();
    #2 mr = 1'b1;
    #1;
    chk("rst_out", int'(out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    q.delete();
    cur = 0;
    #1 mr = 1'b0;
  endtask

  // Issue one operation starting at the current negedge. Returns at the
  // negedge of the done cycle so the next call re-triggers back-to-back.
  // fix: -1 random serial bits, else the constant bit. abort_at: step index
  // at which mr is pulsed (-1 none).
  task automatic op(input int m, input int n, input int d, input int fix,
                    input bit noise, input int abort_at);
    int bits[$];
    int steps, v;
    exp_t e;
    steps = (m inside {1, 2, 4, 5}) ? n : 0;
    for (int i = 0; i < steps; i++)
      bits.push_back(fix < 0 ? int'($urandom_range(0, 1)) : fix);
    v = (m == 3) ? d : cur;
    if (steps == 0) begin
      e.val = v; e.dn = 1'b1; q.push_back(e);
    end else begin
      e.val = v; e.dn = 1'b0; q.push_back(e);
      for (int i = 0; i < steps; i++) begin
        v = mstep(m, v, bits[i]);
        e.val = v; e.dn = (i == steps - 1); q.push_back(e);
      end
    end
    cur = v;

    start = 1'b1; mode = 3'(m); amt = CW'(n); in = 8'(d);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < steps; i++) begin
      dsr = bits[i][0];
      dsl = bits[i][0];
      if (noise) begin
        // Requests during RUN must be ignored.
        start = 1'b1; mode = 3'd3; in = 8'($urandom); amt = CW'($urandom);
      end
      if (i == abort_at) begin
        pulse_reset();
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("init_out", int'(out), 0);
    chk("init_busy", int'(busy), 0);
    chk("init_done", int'(done), 0);
    chk("init_sout", int'({sout_r, sout_l}), 0);
    mr = 1'b0;
    @(negedge clk);

    // preload then asynchronous reset between edges
    op(3, 0, 8'hA5, 0, 0, -1);
    @(negedge clk);
    pulse_reset();
    @(negedge clk);

    op(1, 3, 0, 1, 0, -1);            // 01, 03, 07
    op(3, 0, 8'h81, 0, 0, -1);
    op(4, 1, 0, 0, 0, -1);            // 03
    op(3, 0, 8'h96, 0, 0, -1);
    op(5, 8, 0, 0, 0, -1);            // 96
    op(3, 0, 8'hF0, 0, 0, -1);
    op(2, 2, 0, 0, 0, -1);            // 3C
    op(3, 0, 8'h00, 0, 0, -1);
    op(1, 4, 0, 1, 1, -1);            // LOAD during RUN ignored -> 0F
    op(3, 0, 8'h00, 0, 0, -1);
    op(1, 4, 0, 1, 0, 1);             // reset at 2nd step
    op(3, 0, 8'h5A, 0, 0, -1);
    op(1, 0, 0, 1, 0, -1);            // amt=0: no steps
    op(6, 5, 0, 1, 0, -1);            // reserved mode: hold
    op(7, 3, 0, 1, 0, -1);

    for (int k = 0; k < 60; k++)
      op(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)),
         int'($urandom_range(0, 255)), -1, bit'($urandom_range(0, 1)), -1);

    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("final_out", int'(out), cur);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: WIDTH-bit generalisation of the 4-bit 194-style register (hold, shift right, shift left, parallel load) with added rotate modes and a multi-step shift sequencer. One start pulse runs `amt` single-bit steps on consecutive clocks, reported through a busy/done handshake. Used in the sequential-circuits lab set as the datapath register for serial/parallel conversion and barrel-style shifts built from repeated steps.

## Interface
Parameters:
- WIDTH, 8, register width (≥2)
- CNT_W, derived localparam = $clog2(WIDTH+1), width of `amt` and the step counter

Ports:
- clk  in  1  clock; all state changes on rising edge
- mr  in  1  reset, asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- mode  in  3  operation, captured with start
- amt  in  CNT_W  number of single-bit steps, captured with start
- dsr  in  1  serial input for shift right; enters out[0]
- dsl  in  1  serial input for shift left; enters out[WIDTH-1]
- in  in  WIDTH  parallel load data
- out  out  WIDTH  register contents
- busy  out  1  high while steps are executing
- done  out  1  one-cycle completion pulse
- sout_r  out  1  = out[WIDTH-1] (combinational), for cascading right
- sout_l  out  1  = out[0] (combinational), for cascading left

## Operation
- Modes: 0 HOLD; 1 SHR: out[i]←out[i-1], out[0]←dsr; 2 SHL: out[i]←out[i+1], out[WIDTH-1]←dsl; 3 LOAD: out←in; 4 ROR: as SHR with out[0]←old out[WIDTH-1]; 5 ROL: as SHL with out[WIDTH-1]←old out[0]; 6, 7 reserved, behave as HOLD.
- FSM states IDLE, RUN.
- IDLE, start=1:
  - LOAD: out←in at that edge; done=1 next cycle; stay IDLE.
  - HOLD, reserved mode, or amt=0 on any stepping mode: out unchanged; done=1 next cycle; stay IDLE.
  - SHR/SHL/ROR/ROL with amt≥1: latch mode, set cnt←amt, go RUN.
- RUN: one step per edge, cnt decrements. After the step with cnt=1, go IDLE with done=1.
- dsr/dsl are sampled live at each step edge, so a serial stream can be fed one bit per cycle.
- amt is not clamped. Steps executed = amt exactly, e.g. ROR with amt=WIDTH returns the original value.
- start in RUN is ignored, and mode/amt/in changes during RUN have no effect.
- start in the done cycle is accepted, because the FSM is already IDLE.
- mr asserted at any time, including mid-RUN: out=0, busy=0, done=0, state IDLE, cnt=0, immediately and without waiting for a clock edge.

## Timing
- Reset values: out=0, busy=0, done=0; sout_r=sout_l=0.
- start sampled at edge k, stepping mode, amt=N:
  - steps occur at edges k+1 … k+N;
  - busy=1 from after edge k until edge k+N;
  - done=1 for exactly the cycle after edge k+N, with busy=0 in that cycle.
- Zero-step cases (LOAD, HOLD, reserved, amt=0): busy never asserts; done=1 for the cycle after edge k. For LOAD, out is valid in that same cycle.
- Back-to-back: start held high re-triggers in the done cycle. Throughput is N+1 cycles per N-step operation.
- busy and done are never high together.

## Structure
- Shared package `shift_pkg`:
  - mode constants MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL;
  - FSM state type ST_IDLE, ST_RUN.
- Single module, no sub-module. The one-step next-value function is a combinational block inside univ_shift_reg.

## Test plan
WIDTH=8 throughout.
- Reset: preload 8'hA5, then pulse mr mid-cycle between edges → out=8'h00, busy=0, done=0 immediately; ops resume after release.
- LOAD in=8'hA5 → out=8'hA5 after one edge; done pulses one cycle; busy stays 0.
- From 8'h00, SHR amt=3 dsr=1 → out sequence 8'h01, 8'h03, 8'h07; busy high for 3 cycles, then done for 1.
- ROR amt=1 on 8'h81 → 8'h03. ROL amt=8 on 8'h96 → 8'h96. SHL amt=2 dsl=0 on 8'hF0 → 8'h3C.
- Start SHR amt=4 dsr=1 on 8'h00, pulse start with LOAD during RUN → LOAD ignored, result 8'h0F. Repeat with mr at the 2nd step → out=0, FSM IDLE, no done.
- SHR amt=0, then mode=6 amt=5 on 8'h5A → out stays 8'h5A; done pulses after each with busy=0. Start held high → accepted in the done cycle.
